// File: rtl/convn_valid_tap_accum_if.sv
// Stream bundle for the convolution tap accumulator: the product beat stream in,
// the window-sum result out, and the control/status lines riding alongside.
interface convn_valid_tap_accum_if #(
  parameter int DIN_WIDTH = 62,
  parameter int ACC_WIDTH = 64
) ();
  logic                 ce;
  logic                 clear;
  logic                 in_valid;
  logic                 in_ready;
  logic [DIN_WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 out_overflow;
  logic                 busy;

  modport master (
    output ce, clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_overflow, busy
  );

  modport slave (
    input  ce, clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_overflow, busy
  );
endinterface

// File: rtl/convn_valid_tap_accum.sv
// Sums TAPS consecutive multiplier products into one valid-mode convolution pixel
// and presents it through a one-entry valid/ready result buffer.
module convn_valid_tap_accum #(
  parameter int DIN_WIDTH = 62,
  parameter int ACC_WIDTH = 64,
  parameter int TAPS      = 9,
  parameter int CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  convn_valid_tap_accum_if.slave    bus
);

  typedef struct packed {
    logic                 ovf;
    logic [ACC_WIDTH-1:0] sum;
  } res_t;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(TAPS - 1);

  // window state
  logic [ACC_WIDTH-1:0] acc, acc_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 wovf, wovf_nxt;
  logic                 busy_q;

  // result buffer
  res_t                 res;
  logic                 res_vld;

  logic                 in_ready;
  logic                 take;
  logic                 drain;
  logic                 last;
  logic                 new_res;
  logic [ACC_WIDTH:0]   sum;

  // Ready only looks at the buffer so a full buffer stalls even non-last beats,
  // keeping the partial window frozen rather than running ahead of the consumer.
  assign in_ready = !res_vld || bus.out_ready;
  assign take     = bus.ce && bus.in_valid && in_ready;
  assign drain    = bus.ce && res_vld && bus.out_ready;
  assign last     = (cnt == LAST_CNT);
  assign sum      = {1'b0, acc} + (ACC_WIDTH + 1)'(bus.in_data);
  assign new_res  = take && last && !bus.clear;

  always_comb begin
    acc_nxt  = acc;
    cnt_nxt  = cnt;
    wovf_nxt = wovf;
    if (bus.clear) begin
      acc_nxt  = '0;
      cnt_nxt  = '0;
      wovf_nxt = 1'b0;
    end else if (take) begin
      if (last) begin
        acc_nxt  = '0;
        cnt_nxt  = '0;
        wovf_nxt = 1'b0;
      end else begin
        acc_nxt  = sum[ACC_WIDTH-1:0];
        cnt_nxt  = cnt + CNT_WIDTH'(1);
        wovf_nxt = wovf | sum[ACC_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      cnt    <= '0;
      wovf   <= 1'b0;
      busy_q <= 1'b0;
    end else if (bus.ce) begin
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      wovf   <= wovf_nxt;
      busy_q <= (cnt_nxt != '0);
    end
  end

  // A same-cycle drain and new sum leaves the buffer full with the new value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res     <= '0;
      res_vld <= 1'b0;
    end else if (bus.ce) begin
      if (new_res) begin
        res.sum <= sum[ACC_WIDTH-1:0];
        res.ovf <= wovf | sum[ACC_WIDTH];
      end
      res_vld <= new_res | (res_vld & !drain);
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = res_vld;
  assign bus.out_data     = res.sum;
  assign bus.out_overflow = res.ovf;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_convn_valid_tap_accum.sv
// Directed and random stimulus for the tap accumulator, checked every cycle
// against a queue-based window model.
module tb_convn_valid_tap_accum;
  localparam int DW   = 62;
  localparam int AW   = 64;
  localparam int TAPS = 9;

  logic clk;
  logic reset;
  int   vecs;
  int   errs;

  convn_valid_tap_accum_if #(.DIN_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

  convn_valid_tap_accum #(.DIN_WIDTH(DW), .ACC_WIDTH(AW), .TAPS(TAPS), .CNT_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: beats of the open window, and the result buffer
  logic [DW-1:0] q[$];
  logic          m_ov   = 1'b0;
  logic [AW-1:0] m_data = '0;
  logic          m_ovf  = 1'b0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      if (errs <= 40) $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        q.delete();
        m_ov = 1'b0; m_data = '0; m_ovf = 1'b0;
      end else if (bus.ce) begin
        logic acc_ok, drn, nres;
        logic [127:0] s;
        acc_ok = bus.in_valid && (!m_ov || bus.out_ready);
        drn    = m_ov && bus.out_ready;
        nres   = 1'b0;
        if (bus.clear) q.delete();
        else if (acc_ok) begin
          q.push_back(bus.in_data);
          if (q.size() == TAPS) begin
            s = '0;
            foreach (q[i]) s += 128'(q[i]);
            m_data = s[AW-1:0];
            m_ovf  = |s[127:AW];
            nres   = 1'b1;
            q.delete();
          end
        end
        if (nres) m_ov = 1'b1;
        else if (drn) m_ov = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_out_valid", 64'(bus.out_valid), 64'(m_ov));
      chk("cyc_out_data", bus.out_data, m_data);
      chk("cyc_out_overflow", 64'(bus.out_overflow), 64'(m_ovf));
      chk("cyc_busy", 64'(bus.busy), 64'(q.size() != 0));
      chk("cyc_in_ready", 64'(bus.in_ready), 64'(!m_ov || bus.out_ready));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beats(input int n, input logic [DW-1:0] d);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1; bus.in_data = d; step();
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] maxv;
    logic [63:0]   r;
    vecs = 0; errs = 0;
    maxv = '1;
    reset = 1'b1;
    bus.ce = 1'b1; bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    #2;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_out_data", bus.out_data, 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    step(); step();
    reset = 1'b0;
    step();

    // basic 1..9
    for (int i = 1; i <= 9; i++) begin
      bus.in_valid = 1'b1; bus.in_data = DW'(i); step();
      if (i < 9) chk("basic_busy", 64'(bus.busy), 64'd1);
    end
    bus.in_valid = 1'b0;
    chk("basic_valid", 64'(bus.out_valid), 64'd1);
    chk("basic_sum", bus.out_data, 64'd45);
    chk("basic_model_pin", m_data, 64'd45);
    chk("basic_ovf", 64'(bus.out_overflow), 64'd0);
    chk("basic_busy_end", 64'(bus.busy), 64'd0);
    step();
    chk("basic_pulse", 64'(bus.out_valid), 64'd0);

    // back-pressure: full buffer blocks every beat until drained
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      bus.in_valid = 1'b1; bus.in_data = DW'(i); step();
    end
    bus.in_data = DW'(2);
    #1;
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    step(); step();
    chk("bp_hold_data", bus.out_data, 64'd45);
    chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_no_accept", 64'(bus.busy), 64'd0);
    bus.out_ready = 1'b1;
    beats(9, DW'(2));
    chk("bp_sum", bus.out_data, 64'd18);
    chk("bp_valid", 64'(bus.out_valid), 64'd1);
    step();

    // overflow then a clean window back-to-back
    for (int i = 0; i < 18; i++) begin
      bus.in_valid = 1'b1; bus.in_data = (i < 9) ? maxv : DW'(1); step();
      if (i == 8) begin
        chk("ovf_sum", bus.out_data, 64'h3FFF_FFFF_FFFF_FFF7);
        chk("ovf_flag", 64'(bus.out_overflow), 64'd1);
        chk("ovf_model_pin", 64'(m_ovf), 64'd1);
      end
    end
    bus.in_valid = 1'b0;
    chk("ovf_next_sum", bus.out_data, 64'd9);
    chk("ovf_next_flag", 64'(bus.out_overflow), 64'd0);
    step();

    // ce gating
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = DW'(i); step();
    end
    bus.ce = 1'b0; bus.in_data = DW'(100); bus.clear = 1'b1;
    repeat (5) step();
    chk("ce_busy_held", 64'(bus.busy), 64'd1);
    chk("ce_no_result", 64'(bus.out_valid), 64'd0);
    bus.ce = 1'b1; bus.clear = 1'b0;
    for (int i = 5; i <= 9; i++) begin
      bus.in_valid = 1'b1; bus.in_data = DW'(i); step();
    end
    bus.in_valid = 1'b0;
    chk("ce_sum", bus.out_data, 64'd45);
    step();

    // clear mid-window discards the same-cycle beat
    beats(4, DW'(7));
    bus.clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = DW'(50); step();
    bus.clear = 1'b0;
    chk("clr_busy", 64'(bus.busy), 64'd0);
    beats(9, DW'(1));
    chk("clr_sum", bus.out_data, 64'd9);
    step();

    // async reset with a held result, then mid-window
    bus.out_ready = 1'b0;
    beats(9, DW'(5));
    chk("rst_pre_valid", 64'(bus.out_valid), 64'd1);
    reset = 1'b1; #2;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", bus.out_data, 64'd0);
    chk("rst_ovf", 64'(bus.out_overflow), 64'd0);
    step();
    reset = 1'b0; bus.out_ready = 1'b1;
    beats(5, DW'(4));
    chk("rst_pre_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1; #2;
    chk("rst_mid_busy", 64'(bus.busy), 64'd0);
    chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    step();
    reset = 1'b0;
    beats(9, DW'(3));
    chk("rst_after_sum", bus.out_data, 64'd27);
    step();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      r = {$urandom(), $urandom()};
      bus.ce        = ($urandom_range(0, 9) != 0);
      bus.clear     = ($urandom_range(0, 39) == 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       bus.in_data = maxv;
        1:       bus.in_data = DW'(r[7:0]);
        default: bus.in_data = r[DW-1:0];
      endcase
      step();
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
